fifo_access_ctrl: RTL
=====================

# fifo_access_ctrl

Access controller that sequences all traffic into and out of one shared `fifo` instance (WIDTH/DEPTH matched). N producers compete for the write port under round-robin with bounded bursts. One consumer issues pops. The block guarantees `shift_in` and `shift_out` are never asserted in the same cycle, because the FIFO does not support simultaneous push and pop. It sits directly in front of the FIFO and is the only driver of its control inputs.

## Interface
- `WIDTH`, 32, data word width; equals the FIFO `WIDTH`.
- `N`, 4, number of producers; power of two, ≥2.
- `MAX_BURST`, 4, maximum words one producer writes per grant; ≥1.
- `clk`  in  1  single clock, rising edge.
- `res`  in  1  reset, asynchronous, active-high.
- `req`  in  N  producer i requests to write; held until acked or withdrawn.
- `wdata_in`  in  N*WIDTH  producer i data at bits [i*WIDTH +: WIDTH].
- `ack`  out  N  one-hot; word of producer i written this cycle.
- `pop_req`  in  1  consumer requests one word.
- `pop_ack`  out  1  pop issued this cycle; consumer takes FIFO `rdata` per FIFO read timing.
- `fifo_full`, `fifo_empty`  in  1  FIFO status.
- `fifo_wdata`  out  WIDTH  to FIFO `wdata`.
- `fifo_shift_in`, `fifo_shift_out`  out  1  to FIFO.
- `grant_id`  out  log2(N)  current owner; 0 when idle.
- `busy`  out  1  high in OWN state.

## Operation
- State machine has two states: IDLE and OWN. Registers: `state`, `owner`, `rr_ptr`, `burst_cnt` (log2(MAX_BURST)+1 bits), `turn` (0=write preferred, 1=read preferred).
- **IDLE:**
  - If any `req` is high: pick the first requester at or after `rr_ptr`, scanning upward and wrapping at N-1→0.
  - Load `owner`, clear `burst_cnt`, go to OWN.
  - If no `req` is high, stay in IDLE.
- **Write eligibility:** `wr_ok` = OWN & `req[owner]` & !`fifo_full`.
- **Read eligibility:** `rd_ok` = `pop_req` & !`fifo_empty`. This is independent of state.
- **Conflict resolution:**
  - If both are eligible, `turn` picks the winner, then `turn` flips to favour the loser.
  - If only one is eligible, it is issued and `turn` is unchanged.
- **Outputs:**
  - `fifo_shift_in` = `ack[owner]` = `wr_ok` & won.
  - `fifo_shift_out` = `pop_ack` = `rd_ok` & won.
  - `fifo_wdata` = `wdata_in[owner]` whenever in OWN, else 0.
- **OWN exit and stall:**
  - Each write increments `burst_cnt`.
  - Leave OWN→IDLE when the write raising `burst_cnt` to MAX_BURST occurs, or when `req[owner]` is low at a clock edge.
  - On exit, `rr_ptr` ← `owner`+1 mod N.
  - FIFO full while owning means stall: no ack, `burst_cnt` holds, state holds. There is no timeout.
- A producer dropping `req` without an ack loses its grant. Its word is not written.

## Timing
- **Reset values:** `state`=IDLE, `owner`=0, `rr_ptr`=0, `burst_cnt`=0, `turn`=0. All outputs are 0, including `fifo_wdata` and `grant_id`.
- **Reset gating:** outputs are forced low combinationally while `res` is high, including mid-burst. No shift is issued during reset.
- **Write latency:** `req` rises at edge t (IDLE); grant is registered at t+1; the earliest `ack` is in cycle t+1. Back-to-back acks follow every cycle while the owner keeps `req` high and writes win.
- **Re-grant gap:** between owners there is exactly one IDLE cycle (no writes); pops may proceed during it.
- **Pop latency:** `pop_ack` is combinational in the same cycle as `pop_req` when eligible.
- **Boundaries:**
  - `fifo_full` blocks writes only; `fifo_empty` blocks reads only.
  - A pop on a full FIFO clears full for the next cycle, so a write can follow.
  - `rr_ptr` wraps from N-1 to 0.

## Structure
- The shared include holds the existing `log2` function plus localparams `ST_IDLE`=1'b0, `ST_OWN`=1'b1, `TURN_WR`=0, `TURN_RD`=1.
- Sub-module `rr_pick` (combinational): inputs `req[N]` and `start[log2 N]`; outputs `found` and `idx`. It is reusable by other arbiters.
- The top level holds the FSM, counters, conflict logic, and muxes.

## Test plan
Settings: N=4, WIDTH=32, MAX_BURST=4, FIFO DEPTH=8.
- **Single producer:** reset, then `req[2]` held with data 0xA0..0xA5. Expect grant_id=2 one cycle later; 4 acks (0xA0–0xA3); 1 IDLE cycle; re-grant to 2; then 0xA4, 0xA5.
- **Round-robin:** all four `req` held high. Expect owner order 0,1,2,3,0, each writing up to 4 words or stopping on full; `rr_ptr` wraps 3→0.
- **Full:** fill 8 words with no pops. `fifo_full` blocks: ack stays 0 and `burst_cnt` frozen. One `pop_req` then yields `pop_ack`, and the write proceeds next cycle.
- **Simultaneous push/pop:** owner writing with `pop_req` held and FIFO non-empty. `shift_in`/`shift_out` alternate W,R,W,R…; both are never high in the same cycle (checked every cycle by assertion).
- **Empty pop:** `pop_req` high with FIFO empty gives no `pop_ack`; the first write is followed by `pop_ack` next cycle.
- **Reset mid-burst:** assert `res` after the 2nd ack of a burst. All outputs are 0 immediately. After release, expect state IDLE, `rr_ptr`=0, and a fresh grant to the lowest requester.

Source files
------------

// File: rtl/fifo_access_ctrl_pkg.sv
// fifo_access_ctrl_pkg: shared FSM encodings, turn encodings and the log2 helper
package fifo_access_ctrl_pkg;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_OWN  = 1'b1;
    localparam logic TURN_WR = 1'b0;
    localparam logic TURN_RD = 1'b1;

    function automatic int log2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction
endpackage

// File: rtl/fifo_access_ctrl_rr_pick.sv
// rr_pick: first asserted request at or after start, wrapping N-1 -> 0
module rr_pick
    import fifo_access_ctrl_pkg::*;
#(
    parameter int N = 4,
    parameter int W = log2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);
    logic [N-1:0] rot;

    assign rot   = N'({req, req} >> start);
    assign found = |req;

    // Descending scan so the lowest rotated position wins
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) idx = start + W'(k);
    end
endmodule

// File: rtl/fifo_access_ctrl.sv
// fifo_access_ctrl: round-robin burst writer arbitration plus pop sequencing
// for one shared FIFO, never pushing and popping in the same cycle
module fifo_access_ctrl
    import fifo_access_ctrl_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int N         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   wdata_in,
    output logic [N-1:0]         ack,
    input  logic                 pop_req,
    output logic                 pop_ack,
    input  logic                 fifo_full,
    input  logic                 fifo_empty,
    output logic [WIDTH-1:0]     fifo_wdata,
    output logic                 fifo_shift_in,
    output logic                 fifo_shift_out,
    output logic [log2(N)-1:0]   grant_id,
    output logic                 busy
);
    localparam int IW = log2(N);
    localparam int BW = log2(MAX_BURST) + 1;

    logic          state, state_nx;
    logic [IW-1:0] owner, rr_ptr, pick_idx;
    logic [BW-1:0] burst_cnt;
    logic          turn;
    logic          found, own, wr_ok, rd_ok, wr_win, rd_win, last_wr, leave;

    rr_pick #(.N(N), .W(IW)) u_pick (
        .req   (req),
        .start (rr_ptr),
        .found (found),
        .idx   (pick_idx)
    );

    assign own     = state == ST_OWN;
    assign wr_ok   = own & req[owner] & ~fifo_full;
    assign rd_ok   = pop_req & ~fifo_empty;
    assign wr_win  = wr_ok & (~rd_ok | turn == TURN_WR);
    assign rd_win  = rd_ok & (~wr_ok | turn == TURN_RD);
    assign last_wr = wr_win & (burst_cnt == BW'(MAX_BURST - 1));
    assign leave   = own & (last_wr | ~req[owner]);

    always_ff @(posedge clk or posedge res) begin
        if (res) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = own ? (leave ? ST_IDLE : ST_OWN) : (found ? ST_OWN : ST_IDLE);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            turn      <= TURN_WR;
        end else begin
            if (!own && found) begin
                owner     <= pick_idx;
                burst_cnt <= '0;
            end else if (wr_win) begin
                burst_cnt <= burst_cnt + BW'(1);
            end
            if (leave) rr_ptr <= owner + IW'(1);
            // A contested cycle hands the next contest to the loser
            if (wr_ok && rd_ok) turn <= ~turn;
        end
    end

    always_comb begin
        ack            = (!res && wr_win) ? ({{(N-1){1'b0}}, 1'b1} << owner) : '0;
        fifo_shift_in  = !res && wr_win;
        fifo_shift_out = !res && rd_win;
        pop_ack        = !res && rd_win;
        fifo_wdata     = (!res && own) ? wdata_in[owner*WIDTH +: WIDTH] : '0;
        grant_id       = (!res && own) ? owner : '0;
        busy           = !res && own;
    end
endmodule
